// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the pipelined RV32I core.
//   - Owns the program counter.
//   - Drives the combinational instruction memory.
//   - Holds the IF/ID pipeline register that feeds the decoder.
//   - Stall from the hazard logic freezes the PC and the IF/ID register.
//   - A redirect from EX (jump_flag_i/jump_target_i) loads the PC with the target
//     and flushes the IF/ID slot with a NOP bubble.
//   - A misaligned redirect target raises a sticky fault and halts the stage
//     until reset.
//
// Ports
//   clk_i             clock, all state updates on rising edge
//   reset_i           synchronous, active-high reset
//   stall_i           hold PC and IF/ID register this cycle
//   jump_flag_i       redirect request from EX
//   jump_target_i     redirect address
//   imem_addr_o       instruction memory address (always equals the PC)
//   imem_data_i       instruction word, valid in the same cycle as imem_addr_o
//   if_id_valid_o     IF/ID slot holds a real instruction
//   if_id_pc_o        PC of the instruction in IF/ID
//   if_id_pc_plus4_o  if_id_pc_o + 4, used for the JAL/JALR link value
//   if_id_inst_o      instruction in IF/ID (NOP_INST when the slot is invalid)
//   fetch_fault_o     sticky: a misaligned redirect was seen and the stage halted
//   fetch_count_o     number of instructions loaded into IF/ID (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             stall_i,
   input  logic             jump_flag_i,
   input  logic [31:0]      jump_target_i,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_data_i,
   output logic             if_id_valid_o,
   output logic [31:0]      if_id_pc_o,
   output logic [31:0]      if_id_pc_plus4_o,
   output logic [31:0]      if_id_inst_o,
   output logic             fetch_fault_o,
   output logic [CNT_W-1:0] fetch_count_o
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   state_t            state_q,    state_d;
   logic [31:0]       pc_q,       pc_d;
   logic              valid_q,    valid_d;
   logic [31:0]       id_pc_q,    id_pc_d;
   logic [31:0]       id_pc4_q,   id_pc4_d;
   logic [31:0]       id_inst_q,  id_inst_d;
   logic              fault_q,    fault_d;
   logic [CNT_W-1:0]  count_q,    count_d;

   logic [31:0]       pc_plus4_s;
   logic              target_misaligned_s;

   // Sequential address and redirect-alignment helpers.
   always_comb begin
      pc_plus4_s          = pc_q + 32'd4;   // 32-bit modulo wrap is intended
      target_misaligned_s = (jump_target_i[1:0] != 2'b00);
   end

   // Next-state logic: FSM transitions and IF/ID/PC updates.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = valid_q;
      id_pc_d   = id_pc_q;
      id_pc4_d  = id_pc4_q;
      id_inst_d = id_inst_q;
      fault_d   = fault_q;
      count_d   = count_q;

      case (state_q)
         ST_BOOT: begin
            // One idle cycle after reset; the slot stays invalid and inputs are ignored.
            state_d = ST_RUN;
         end

         ST_RUN: begin
            if (jump_flag_i) begin
               // Redirect beats stall: the word fetched this cycle is discarded.
               valid_d   = 1'b0;
               id_inst_d = NOP_INST;
               if (target_misaligned_s) begin
                  fault_d = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  pc_d = jump_target_i;
               end
            end else if (stall_i) begin
               // Hold everything.
               state_d = ST_RUN;
            end else begin
               valid_d   = 1'b1;
               id_pc_d   = pc_q;
               id_pc4_d  = pc_plus4_s;
               id_inst_d = imem_data_i;
               pc_d      = pc_plus4_s;
               count_d   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end

         ST_HALT: begin
            // Parked until reset: keep emitting bubbles, fault stays set.
            valid_d   = 1'b0;
            id_inst_d = NOP_INST;
         end

         default: begin
            state_d   = ST_BOOT;
            valid_d   = 1'b0;
            id_inst_d = NOP_INST;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_BOOT;
         pc_q      <= RESET_PC;
         valid_q   <= 1'b0;
         id_pc_q   <= 32'h0000_0000;
         id_pc4_q  <= 32'h0000_0004;
         id_inst_q <= NOP_INST;
         fault_q   <= 1'b0;
         count_q   <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         id_pc_q   <= id_pc_d;
         id_pc4_q  <= id_pc4_d;
         id_inst_q <= id_inst_d;
         fault_q   <= fault_d;
         count_q   <= count_d;
      end
   end

   // All outputs come straight from registers.
   always_comb begin
      imem_addr_o      = pc_q;
      if_id_valid_o    = valid_q;
      if_id_pc_o       = id_pc_q;
      if_id_pc_plus4_o = id_pc4_q;
      if_id_inst_o     = id_inst_q;
      fetch_fault_o    = fault_q;
      fetch_count_o    = count_q;
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        jump_flag;
   logic [31:0] jump_target;

   // DUT A: default reset PC
   logic [31:0] a_imem_addr, a_imem_data, a_pc, a_pc4, a_inst;
   logic        a_valid, a_fault;
   logic [31:0] a_count;

   // DUT B: reset PC at the top of the address space
   logic [31:0] b_imem_addr, b_imem_data, b_pc, b_pc4, b_inst;
   logic        b_valid, b_fault;
   logic [31:0] b_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Instruction memory model: fixed word at 0, address-derived word elsewhere.
   function automatic logic [31:0] imem_model(input logic [31:0] addr);
      if (addr == 32'h0000_0000) return 32'h00A0_0093;
      return (addr << 8) | 32'h0000_0013;
   endfunction

   assign a_imem_data = imem_model(a_imem_addr);
   assign b_imem_data = imem_model(b_imem_addr);

   fetch_stage u_dut_a (
      .clk_i(clk), .reset_i(reset), .stall_i(stall),
      .jump_flag_i(jump_flag), .jump_target_i(jump_target),
      .imem_addr_o(a_imem_addr), .imem_data_i(a_imem_data),
      .if_id_valid_o(a_valid), .if_id_pc_o(a_pc), .if_id_pc_plus4_o(a_pc4),
      .if_id_inst_o(a_inst), .fetch_fault_o(a_fault), .fetch_count_o(a_count)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
      .clk_i(clk), .reset_i(reset), .stall_i(stall),
      .jump_flag_i(jump_flag), .jump_target_i(jump_target),
      .imem_addr_o(b_imem_addr), .imem_data_i(b_imem_data),
      .if_id_valid_o(b_valid), .if_id_pc_o(b_pc), .if_id_pc_plus4_o(b_pc4),
      .if_id_inst_o(b_inst), .fetch_fault_o(b_fault), .fetch_count_o(b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full snapshot of DUT A against expected values.
   task automatic check_a(input string tag, input logic [31:0] addr, input logic valid,
                          input logic [31:0] pc, input logic [31:0] inst,
                          input logic fault, input logic [31:0] cnt);
      check({tag, ".imem_addr"}, a_imem_addr, addr);
      check({tag, ".valid"},     {31'd0, a_valid}, {31'd0, valid});
      check({tag, ".if_id_pc"},  a_pc, pc);
      check({tag, ".pc_plus4"},  a_pc4, pc + 32'd4);
      check({tag, ".inst"},      a_inst, inst);
      check({tag, ".fault"},     {31'd0, a_fault}, {31'd0, fault});
      check({tag, ".count"},     a_count, cnt);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; jump_flag = 1'b0; jump_target = 32'h0;

      // 1. reset then BOOT then first fetch
      step(); step();
      check_a("reset", 32'h0, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0);
      reset = 1'b0;
      step();
      check_a("boot", 32'h0, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0);
      step();
      check_a("fetch0", 32'h4, 1'b1, 32'h0, 32'h00A0_0093, 1'b0, 32'd1);

      // 2. straight run
      for (int i = 1; i < 4; i++) begin
         step();
         check_a("run", 32'(4*i + 4), 1'b1, 32'(4*i), imem_model(32'(4*i)), 1'b0, 32'(i + 1));
      end

      // 3. stall freezes everything
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_a("stall", 32'h10, 1'b1, 32'hC, imem_model(32'hC), 1'b0, 32'd4);
      end
      stall = 1'b0;
      step();
      check_a("resume", 32'h14, 1'b1, 32'h10, imem_model(32'h10), 1'b0, 32'd5);

      // 4. redirect wins over simultaneous stall
      jump_flag = 1'b1; jump_target = 32'h100; stall = 1'b1;
      step();
      check_a("jump_bubble", 32'h100, 1'b0, 32'h10, 32'h13, 1'b0, 32'd5);
      jump_flag = 1'b0; stall = 1'b0;
      step();
      check_a("jump_target", 32'h104, 1'b1, 32'h100, imem_model(32'h100), 1'b0, 32'd6);

      // 5. misaligned redirect -> sticky fault, halted
      jump_flag = 1'b1; jump_target = 32'h102;
      step();
      check_a("fault", 32'h104, 1'b0, 32'h100, 32'h13, 1'b1, 32'd6);
      for (int i = 0; i < 10; i++) begin
         jump_flag   = i[0];
         stall       = i[1];
         jump_target = 32'h200;
         step();
         check_a("halt", 32'h104, 1'b0, 32'h100, 32'h13, 1'b1, 32'd6);
      end
      jump_flag = 1'b0; stall = 1'b0;
      reset = 1'b1;
      step();
      check_a("fault_clear", 32'h0, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0);

      // 6. PC wrap on DUT B
      check("b_reset.imem_addr", b_imem_addr, 32'hFFFF_FFFC);
      reset = 1'b0;
      step();
      check("b_boot.valid", {31'd0, b_valid}, 32'd0);
      step();
      check("b_wrap.imem_addr", b_imem_addr, 32'h0);
      check("b_wrap.if_id_pc", b_pc, 32'hFFFF_FFFC);
      check("b_wrap.pc_plus4", b_pc4, 32'h0);
      check("b_wrap.inst", b_inst, imem_model(32'hFFFF_FFFC));
      check("b_wrap.count", b_count, 32'd1);
      step();
      check("a_mid.if_id_pc", a_pc, 32'h4);

      // reset mid-run with stall and jump active
      reset = 1'b1; stall = 1'b1; jump_flag = 1'b1; jump_target = 32'h40;
      step();
      check_a("mid_reset", 32'h0, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0);
      check("b_mid_reset.imem_addr", b_imem_addr, 32'hFFFF_FFFC);
      check("b_mid_reset.count", b_count, 32'd0);
      reset = 1'b0; stall = 1'b0; jump_flag = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
